// File: rtl/seven_segment_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment driver.
package seven_segment_pkg;

  // Segment bit positions inside the 8-bit cathode word.
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Hex digit to segment pattern, active-high, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Clock cycles spent on one digit per refresh frame.
  function automatic int calc_interval(input int clk_per, input int refr_rate,
                                       input int num_digits);
    longint den;
    den = longint'(clk_per) * longint'(refr_rate) * longint'(num_digits);
    return int'(longint'(1_000_000_000) / den);
  endfunction

  // Clock cycles per PWM sub-slot; leftover cycles of the interval are dropped.
  function automatic int calc_sub(input int interval, input int bright_bits);
    return interval >>> bright_bits;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble plus decimal point to active-high segment word.
module seg_decode
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] segs
);

  // Table lookup for a..g, dp passed straight through.
  always_comb begin
    segs = '0;
    segs[SEG_A +: 7] = HEX_SEG[nibble];
    segs[SEG_DP]     = dp;
  end

endmodule

// File: rtl/seven_segment_mux.sv
// Multiplexed seven-segment driver: stream input with a shadow buffer that
// commits only at frame boundaries, PWM brightness, leading-zero blanking and
// selectable pin polarity.
module seven_segment_mux
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS         = 8,
  parameter int CLK_PER            = 10,
  parameter int REFR_RATE          = 1000,
  parameter int BRIGHT_BITS        = 4,
  parameter int ANODE_ACTIVE_LOW   = 1,
  parameter int CATHODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [NUM_DIGITS*4-1:0] s_tdata,
  input  logic [NUM_DIGITS-1:0]   s_tuser,
  input  logic [BRIGHT_BITS-1:0]  brightness,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              cathode
);

  localparam int INTERVAL = calc_interval(CLK_PER, REFR_RATE, NUM_DIGITS);
  localparam int SUB      = calc_sub(INTERVAL, BRIGHT_BITS);
  localparam int SW       = (SUB > 1) ? $clog2(SUB) : 1;
  localparam int DW       = $clog2(NUM_DIGITS);

  localparam logic [SW-1:0]          SUB_LAST  = SW'(SUB - 1);
  localparam logic [DW-1:0]          DIG_LAST  = DW'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_BITS-1:0] PWM_LAST  = '1;
  localparam logic [NUM_DIGITS-1:0]  ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0]             CATH_OFF  = (CATHODE_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  if (SUB < 2) begin : g_sub_check
    $error("seven_segment_mux: sub-slot length %0d is below 2 cycles", SUB);
  end
  if (NUM_DIGITS < 2) begin : g_digit_check
    $error("seven_segment_mux: NUM_DIGITS must be at least 2");
  end

  logic [SW-1:0]             sub_cnt;
  logic [BRIGHT_BITS-1:0]    pwm_idx;
  logic [DW-1:0]             digit_idx;
  logic                      pending;
  logic [NUM_DIGITS*4-1:0]   shadow_data;
  logic [NUM_DIGITS-1:0]     shadow_user;
  logic [NUM_DIGITS*4-1:0]   act_data;
  logic [NUM_DIGITS-1:0]     act_user;
  logic [NUM_DIGITS-1:0]     blank;

  logic                      sub_wrap;
  logic                      pwm_wrap;
  logic                      frame_bnd;
  logic                      accept;
  logic                      commit;
  logic                      lit;
  logic [3:0]                cur_nib;
  logic                      cur_dp;
  logic [7:0]                cur_segs;
  logic [NUM_DIGITS-1:0]     mask_next;
  logic                      scanning;
  logic [NUM_DIGITS-1:0]     onehot;
  logic [NUM_DIGITS-1:0]     anode_next;
  logic [7:0]                cathode_next;

  // Rst gates ready combinationally so nothing is accepted while held in reset.
  assign s_tready = ~pending & ~rst;

  seg_decode u_seg_decode (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .segs   (cur_segs)
  );

  // Counter wrap chain, handshake/commit strobes and current-digit selection.
  always_comb begin
    sub_wrap  = (sub_cnt == SUB_LAST);
    pwm_wrap  = sub_wrap && (pwm_idx == PWM_LAST);
    frame_bnd = pwm_wrap && (digit_idx == DIG_LAST);
    accept    = s_tvalid && s_tready;
    commit    = frame_bnd && pending;
    cur_nib   = act_data[{digit_idx, 2'b00} +: 4];
    cur_dp    = act_user[digit_idx];
    onehot    = NUM_DIGITS'(1) << digit_idx;
    // sub_cnt == 0 is kept dark so the previous digit cannot ghost into this one.
    lit       = !blank[digit_idx] && (pwm_idx <= brightness) && (sub_cnt != '0);
  end

  // Leading-zero mask from the shadow, scanning from the leftmost digit down.
  always_comb begin
    mask_next = '0;
    scanning  = lz_blank;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (scanning && (shadow_data[4*i +: 4] == 4'h0) && !shadow_user[i]) begin
        mask_next[i] = 1'b1;
      end else begin
        scanning = 1'b0;
      end
    end
  end

  // Pin values for the next cycle with polarity applied.
  always_comb begin
    anode_next   = ANODE_OFF;
    cathode_next = CATH_OFF;
    if (lit) begin
      anode_next   = (ANODE_ACTIVE_LOW != 0) ? ~onehot : onehot;
      cathode_next = (CATHODE_ACTIVE_LOW != 0) ? ~cur_segs : cur_segs;
    end
  end

  // Sub-slot, PWM and digit counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt   <= '0;
      pwm_idx   <= '0;
      digit_idx <= '0;
    end else if (sub_wrap) begin
      sub_cnt <= '0;
      if (pwm_wrap) begin
        pwm_idx   <= '0;
        digit_idx <= frame_bnd ? '0 : digit_idx + 1'b1;
      end else begin
        pwm_idx <= pwm_idx + 1'b1;
      end
    end else begin
      sub_cnt <= sub_cnt + 1'b1;
    end
  end

  // Shadow register and pending flag; accept and commit never coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= 1'b0;
      shadow_data <= '0;
      shadow_user <= '0;
    end else if (accept) begin
      pending     <= 1'b1;
      shadow_data <= s_tdata;
      shadow_user <= s_tuser;
    end else if (commit) begin
      pending <= 1'b0;
    end
  end

  // Active buffer and blank mask change only at a frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_data <= '0;
      act_user <= '0;
      blank    <= '1;
    end else if (commit) begin
      act_data <= shadow_data;
      act_user <= shadow_user;
      blank    <= mask_next;
    end
  end

  // Registered display pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      anode   <= ANODE_OFF;
      cathode <= CATH_OFF;
    end else begin
      anode   <= anode_next;
      cathode <= cathode_next;
    end
  end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Directed bench for seven_segment_mux: four digits, 10-cycle slots, 40-cycle frames.
module tb_seven_segment_mux;

  localparam int FRAME = 40;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  user;
    logic        lz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [15:0] s_tdata = '0;
  logic [3:0]  s_tuser = '0;
  logic [0:0]  brightness = 1'b1;
  logic        lz_blank = 1'b0;
  logic [3:0]  anode;
  logic [7:0]  cathode;

  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  logic [6:0] hex_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  seven_segment_mux #(
    .NUM_DIGITS(4), .CLK_PER(10), .REFR_RATE(2_500_000), .BRIGHT_BITS(1),
    .ANODE_ACTIVE_LOW(1), .CATHODE_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tdata(s_tdata), .s_tuser(s_tuser), .brightness(brightness),
    .lz_blank(lz_blank), .anode(anode), .cathode(cathode)
  );

  always #5 clk = ~clk;

  // Edges since reset release; counter position after edge n is (n mod FRAME).
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] blank_mask(input logic [15:0] d, input logic [3:0] u,
                                            input logic lz);
    logic [3:0] m;
    m = '0;
    if (lz) begin
      for (int i = 3; i >= 1; i--) begin
        if (d[4*i +: 4] != 4'h0 || u[i]) break;
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  // Offer one beat (called at a negedge); returns the edge index that accepted it.
  task automatic send(input logic [15:0] d, input logic [3:0] u, input string tag,
                      output int acc);
    int n;
    n = 0;
    s_tdata  = d;
    s_tuser  = u;
    s_tvalid = 1'b1;
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tready"}, 32'(s_tready), 32'd1);
    acc = cyc + 1;
    exp_q.push_back(exp_t'{d, u, lz_blank});
    @(posedge clk);
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  function automatic int commit_edge(input int acc);
    return (acc / FRAME + 1) * FRAME;
  endfunction

  // Compare one full frame whose first output follows edge 'start'.
  task automatic check_frame(input int start, input string tag);
    exp_t        e;
    logic [3:0]  m;
    logic [3:0]  ea;
    logic [7:0]  ec;
    logic [3:0]  nib;
    int          sub, pwm, dig, lit_n, exp_lit, n;
    logic        on;
    e = exp_q.pop_front();
    m = blank_mask(e.data, e.user, e.lz);
    n = 0;
    while (cyc < start && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_align"}, 32'(cyc), 32'(start));
    lit_n = 0;
    for (int p = 0; p < FRAME; p++) begin
      sub = p % 5;
      pwm = (p / 5) % 2;
      dig = p / 10;
      on  = (sub != 0) && (pwm <= int'(brightness)) && !m[dig];
      nib = e.data[4*dig +: 4];
      ea  = on ? ~(4'b0001 << dig) : 4'hF;
      ec  = on ? ~{e.user[dig], hex_tab[nib]} : 8'hFF;
      chk($sformatf("%s_anode_p%0d", tag, p), 32'(anode), 32'(ea));
      chk($sformatf("%s_cathode_p%0d", tag, p), 32'(cathode), 32'(ec));
      if (anode != 4'hF) lit_n++;
      @(negedge clk);
    end
    exp_lit = 0;
    for (int d = 0; d < 4; d++) if (!m[d]) exp_lit += 4 * (int'(brightness) + 1);
    chk({tag, "_lit_count"}, 32'(lit_n), 32'(exp_lit));
  endtask

  task automatic check_dark(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      chk($sformatf("%s_anode_%0d", tag, i), 32'(anode), 32'hF);
      chk($sformatf("%s_cathode_%0d", tag, i), 32'(cathode), 32'hFF);
      @(negedge clk);
    end
  endtask

  initial begin
    int acc_a, acc_b, acc_c, ca, cb;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_tready", 32'(s_tready), 32'd0);
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_cathode", 32'(cathode), 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    chk("release_tready", 32'(s_tready), 32'd1);
    check_dark(FRAME, "idle");

    // Full brightness, plain digits.
    brightness = 1'b1;
    lz_blank   = 1'b0;
    send(16'h1234, 4'b0000, "b1234", acc_a);
    check_frame(commit_edge(acc_a) + 1, "f1234");

    // Minimum brightness: only the first sub-slot lights.
    brightness = 1'b0;
    send(16'h0008, 4'b0000, "b0008", acc_a);
    check_frame(commit_edge(acc_a) + 1, "f0008");

    // Leading-zero blanking.
    brightness = 1'b1;
    lz_blank   = 1'b1;
    send(16'h0070, 4'b0000, "blz", acc_a);
    check_frame(commit_edge(acc_a) + 1, "flz");

    // A lit decimal point stops the blanking scan.
    send(16'h0070, 4'b1000, "blzdp", acc_a);
    check_frame(commit_edge(acc_a) + 1, "flzdp");

    // Back-to-back beats: B stalls until A commits; frames never mix.
    lz_blank = 1'b0;
    send(16'hABCD, 4'b0001, "bA", acc_a);
    chk("stall_tready", 32'(s_tready), 32'd0);
    ca = commit_edge(acc_a);
    fork
      send(16'h5678, 4'b0010, "bB", acc_b);
      check_frame(ca + 1, "fA");
    join
    chk("b_accept_edge", 32'(acc_b), 32'(ca + 1));
    cb = commit_edge(acc_b);
    check_frame(cb + 1, "fB");

    // Reset while a beat is pending discards it and darkens the display.
    send(16'hFFFF, 4'b1111, "bC", acc_c);
    rst = 1'b1;
    void'(exp_q.pop_front());
    @(negedge clk);
    chk("rst2_tready", 32'(s_tready), 32'd0);
    chk("rst2_anode", 32'(anode), 32'hF);
    chk("rst2_cathode", 32'(cathode), 32'hFF);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_release_tready", 32'(s_tready), 32'd1);
    check_dark(2 * FRAME + 5, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
